// File: rtl/down_timer.sv
// Loadable down-counter with one-shot or periodic terminal-count pulse.
// Two-state IDLE/RUN machine; Q, tc and busy are all registered.
module down_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] Q,
    output logic             tc,
    output logic             busy,
    output logic             zero
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state;
    logic [WIDTH-1:0] reload_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            Q        <= '0;
            reload_q <= '0;
            tc       <= 1'b0;
            state    <= IDLE;
            busy     <= 1'b0;
        end else begin
            tc <= 1'b0;
            if (load) begin
                // Load restarts from any state; a zero value parks the timer.
                Q        <= load_val;
                reload_q <= load_val;
                if (load_val != '0) begin
                    state <= RUN;
                    busy  <= 1'b1;
                end else begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            end else if (state == RUN && en) begin
                if (Q > WIDTH'(1)) begin
                    Q <= Q - WIDTH'(1);
                end else if (Q == WIDTH'(1)) begin
                    tc <= 1'b1;
                    if (auto_reload) begin
                        Q <= reload_q;
                    end else begin
                        Q     <= '0;
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end else begin
                    // Q == 0 in RUN is unreachable; fall back to IDLE without wrapping.
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            end
        end
    end

    assign zero = (Q == '0);

endmodule

// File: doc/down_timer.md
DOWN_TIMER -- requirements
Module: down_timer

Interface
REQ-001 Parameter: WIDTH, default 4, counter width in bits.
REQ-002 Port: clk  input  1  single clock; all state updates on posedge clk.
REQ-003 Port: reset  input  1  reset, synchronous, active-high.
REQ-004 Port: load  input  1  load strobe; captures load_val.
REQ-005 Port: load_val  input  WIDTH  start/reload value.
REQ-006 Port: en  input  1  count enable; one decrement per enabled cycle in RUN.
REQ-007 Port: auto_reload  input  1  1 = periodic mode, 0 = one-shot mode; sampled at terminal count.
REQ-008 Port: Q  output  WIDTH  registered present count.
REQ-009 Port: tc  output  1  registered terminal-count pulse.
REQ-010 Port: busy  output  1  registered; high while state is RUN.
REQ-011 Port: zero  output  1  combinational flag, (Q == 0).

Function
REQ-012 The block SHALL implement a two-state FSM, IDLE and RUN, plus an internal WIDTH-bit reload register.
REQ-013 Priority each cycle SHALL be reset > load > terminal/decrement > hold.
REQ-014 On load=1: Q <= load_val; reload register <= load_val; tc <= 0; next state RUN if load_val != 0, else IDLE; this applies in any state and restarts a running count.
REQ-015 In IDLE without load: Q and reload register SHALL hold; en ignored; tc <= 0.
REQ-016 In RUN with en=0 and no load: Q SHALL hold; tc <= 0; state stays RUN.
REQ-017 In RUN with en=1, Q > 1, no load: Q <= Q - 1; tc <= 0.
REQ-018 In RUN with en=1, Q == 1, no load, auto_reload=0: Q <= 0; tc <= 1; next state IDLE.
REQ-019 In RUN with en=1, Q == 1, no load, auto_reload=1: Q <= reload register value; tc <= 1; state stays RUN.
REQ-020 tc SHALL be high for exactly one cycle per terminal event, in the cycle Q first shows 0 (one-shot) or the reload value (periodic).
REQ-021 Periodic mode with reload value N SHALL produce tc once every N enabled cycles; Q sequence N, N-1, ..., 1, N, ...
REQ-022 Q SHALL never wrap below 0; no decrement SHALL occur from Q == 0.
REQ-023 Load coincident with a terminal event SHALL win: Q <= load_val, tc stays 0 that cycle.
REQ-024 load_val = 0 SHALL leave the block in IDLE with Q = 0 and SHALL NOT generate tc, in either mode.
REQ-025 busy SHALL equal (state == RUN), registered with the state.
REQ-026 Arithmetic SHALL be unsigned modulo-free WIDTH-bit; load_val = 2^WIDTH-1 SHALL count the full range.

Reset
REQ-027 With reset=1 at a clock edge: Q <= 0, reload register <= 0, tc <= 0, state <= IDLE (busy = 0), regardless of load, en or current state.
REQ-028 Reset asserted mid-count SHALL abort the count with no tc pulse; counting resumes only after a new load.

Verification
REQ-029 Reset: reset=1 for 2 cycles from arbitrary state -> Q=0, tc=0, busy=0, zero=1.
REQ-030 One-shot: auto_reload=0, load 5, en=1 continuously -> Q 5,4,3,2,1,0 on successive cycles; tc=1 only in cycle with Q=0; busy falls same cycle; Q stays 0 afterwards.
REQ-031 Periodic: auto_reload=1, load 3, en=1 -> Q 3,2,1,3,2,1,3...; tc=1 in each cycle Q returns to 3; busy stays 1.
REQ-032 Enable gating: load 4, en pattern 1,0,0,1,1,1 -> Q 4,3,3,3,2,1,0; single tc at Q=0.
REQ-033 Collisions: in RUN at Q=1 with en=1 assert load with load_val=9 -> Q=9, tc=0, busy=1; then load_val=0 -> Q=0, busy=0, tc=0.
REQ-034 Reset mid-run: load 15, en=1, reset at Q=7 -> Q=0, busy=0, no tc; en alone afterwards leaves Q=0.
